// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control path: states, opcodes,
// ALUOp and ALU operand selects, plus the per-state Moore control word.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC  = 2'b00;
  localparam logic [1:0] SRCA_RS1 = 2'b01;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore control word for a state; anything not set stays 0.
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_SUB;
        c.pc_source = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive memory-wait cycles and flags a timeout once the count
// has reached MEM_TIMEOUT and memory is still not ready.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wait,
  input  logic i_clear,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] MAXCNT = '1;

  logic [CNT_W-1:0] r_cnt;

  // Saturating so a disabled timeout never wraps the count.
  always_ff @(posedge clk) begin
    if (reset || i_clear || !i_wait) begin
      r_cnt <= '0;
    end else if (r_cnt != MAXCNT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_timeout = (MEM_TIMEOUT != 0) && i_wait && (r_cnt == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32 datapath: fetch/decode/execute/
// memory/writeback sequencing with memory handshake stalls and halt on error.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_source,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state_o
);

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;
  logic   r_illegal;
  logic   r_bus_err;
  logic   w_wait;
  logic   w_state_chg;
  logic   w_timeout;
  logic   w_bad_op;
  logic   w_run;

  assign w_wait      = is_mem_state(r_state) && !mem_ready;
  assign w_state_chg = (w_next != r_state);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .i_wait   (w_wait),
    .i_clear  (w_state_chg),
    .o_timeout(w_timeout)
  );

  // mem_ready wins over a timeout that lands in the same cycle.
  always_comb begin
    w_next   = r_state;
    w_bad_op = 1'b0;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE; else if (w_timeout) w_next = S_HALT;
      S_DECODE: begin
        case (opcode)
          OP_R:              w_next = S_EXEC_R;
          OP_I:              w_next = S_EXEC_I;
          OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
          OP_BRANCH:         w_next = S_BRANCH;
          default: begin
            w_next   = S_HALT;
            w_bad_op = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: w_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB; else if (w_timeout) w_next = S_HALT;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   if (mem_ready) w_next = S_FETCH; else if (w_timeout) w_next = S_HALT;
      S_EXEC_R:   w_next = S_ALU_WB;
      S_EXEC_I:   w_next = S_ALU_WB;
      S_ALU_WB:   w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_HALT;
    endcase
  end

  // Control word is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_ctrl    <= ctrl_decode(S_FETCH);
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_decode(w_next);
      if (w_bad_op)  r_illegal <= 1'b1;
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end

  // Strobes are held off while reset is asserted so an interrupted write never lands.
  assign w_run = !reset;

  assign pc_write   = w_run && (((r_state == S_FETCH) && mem_ready) || ((r_state == S_BRANCH) && zero));
  assign ir_write   = w_run && (r_state == S_FETCH) && mem_ready;
  assign mem_read   = w_run && r_ctrl.mem_read;
  assign mem_write  = w_run && r_ctrl.mem_write;
  assign reg_write  = w_run && r_ctrl.reg_write;
  assign pc_source  = r_ctrl.pc_source;
  assign iord       = r_ctrl.iord;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign alu_src_a  = r_ctrl.alu_src_a;
  assign alu_src_b  = r_ctrl.alu_src_b;
  assign alu_op     = r_ctrl.alu_op;
  assign illegal    = r_illegal;
  assign bus_err    = r_bus_err;
  assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instructions are expanded into per-cycle
// state/handshake traces and every cycle is compared against a control table.
module tb_multicycle_control;

  localparam int TIMEOUT = 16;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEM_ADDR = 2, ST_MEM_RD = 3;
  localparam int ST_MEM_WB = 4, ST_MEM_WR = 5, ST_EXEC_R = 6, ST_EXEC_I = 7;
  localparam int ST_ALU_WB = 8, ST_BRANCH = 9, ST_HALT = 15;

  localparam int KR = 0, KI = 1, KLD = 2, KST = 3, KBR = 4;

  localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011, OPC_BR = 7'b1100011;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [6:0] opcode;
  logic       pc_write, pc_source, ir_write, iord, mem_read, mem_write;
  logic       reg_write, mem_to_reg, illegal, bus_err;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic [3:0] state_o;
  logic [13:0] obsCtrl;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    int st;
    bit rdy;
    bit ill;
    bit bus;
  } step_t;

  step_t trace[$];

  multicycle_control #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_source(pc_source), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal(illegal), .bus_err(bus_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign obsCtrl = {pc_write, pc_source, ir_write, iord, mem_read, mem_write,
                    reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Control table: what each state must drive, given mem_ready and zero.
  function automatic logic [13:0] expCtrl(input int st, input bit rdy, input bit z);
    logic pcw, pcs, irw, ad, mrd, mwr, rw, m2r;
    logic [1:0] a, b, op;
    {pcw, pcs, irw, ad, mrd, mwr, rw, m2r} = 8'b0;
    a = 2'b00; b = 2'b00; op = 2'b00;
    case (st)
      ST_FETCH:    begin mrd = 1; pcw = rdy; irw = rdy; b = 2'b01; end
      ST_DECODE:   b = 2'b10;
      ST_MEM_ADDR: begin a = 2'b01; b = 2'b10; end
      ST_MEM_RD:   begin mrd = 1; ad = 1; end
      ST_MEM_WB:   begin rw = 1; m2r = 1; end
      ST_MEM_WR:   begin mwr = 1; ad = 1; end
      ST_EXEC_R:   begin a = 2'b01; op = 2'b10; end
      ST_EXEC_I:   begin a = 2'b01; b = 2'b10; op = 2'b10; end
      ST_ALU_WB:   rw = 1;
      ST_BRANCH:   begin a = 2'b01; op = 2'b01; pcs = 1; pcw = z; end
      default:     ;
    endcase
    return {pcw, pcs, irw, ad, mrd, mwr, rw, m2r, a, b, op};
  endfunction

  function automatic logic [6:0] opFor(input int kind);
    case (kind)
      KR:      return OPC_R;
      KI:      return OPC_I;
      KLD:     return OPC_LD;
      KST:     return OPC_ST;
      default: return OPC_BR;
    endcase
  endfunction

  function automatic void push(input int st, input bit rdy, input bit ill, input bit bus);
    step_t s;
    s.st = st; s.rdy = rdy; s.ill = ill; s.bus = bus;
    trace.push_back(s);
  endfunction

  function automatic bit coin();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction as a cycle list: fetch waits, decode, then the class-specific phases.
  function automatic void pushInstr(input int kind, input int fWait, input int mWait);
    repeat (fWait) push(ST_FETCH, 1'b0, 1'b0, 1'b0);
    push(ST_FETCH, 1'b1, 1'b0, 1'b0);
    push(ST_DECODE, coin(), 1'b0, 1'b0);
    case (kind)
      KR: begin push(ST_EXEC_R, coin(), 0, 0); push(ST_ALU_WB, coin(), 0, 0); end
      KI: begin push(ST_EXEC_I, coin(), 0, 0); push(ST_ALU_WB, coin(), 0, 0); end
      KLD: begin
        push(ST_MEM_ADDR, coin(), 0, 0);
        repeat (mWait) push(ST_MEM_RD, 1'b0, 0, 0);
        push(ST_MEM_RD, 1'b1, 0, 0);
        push(ST_MEM_WB, coin(), 0, 0);
      end
      KST: begin
        push(ST_MEM_ADDR, coin(), 0, 0);
        repeat (mWait) push(ST_MEM_WR, 1'b0, 0, 0);
        push(ST_MEM_WR, 1'b1, 0, 0);
      end
      default: push(ST_BRANCH, coin(), 0, 0);
    endcase
  endfunction

  task automatic applyStimulus(input logic [6:0] opc, input bit z, input bit rdy, input bit rst);
    opcode = opc; zero = z; mem_ready = rdy; reset = rst;
    @(negedge clk);
  endtask

  task automatic runCycle(input step_t s, input logic [6:0] opc, input bit z);
    applyStimulus(opc, z, s.rdy, 1'b0);
    checkOutput("state", 32'(state_o), 32'(s.st));
    checkOutput("ctrl", 32'(obsCtrl), 32'(expCtrl(s.st, s.rdy, z)));
    checkOutput("flags", {30'b0, illegal, bus_err}, {30'b0, s.ill, s.bus});
    @(posedge clk); #1;
  endtask

  // zMode: 0/1 force zero, 2 randomises it every cycle. Fetch sees junk opcodes.
  task automatic runTrace(input logic [6:0] opc, input int zMode);
    step_t s;
    logic [6:0] drv;
    bit z;
    while (trace.size() > 0) begin
      s   = trace.pop_front();
      drv = (s.st == ST_FETCH) ? 7'($urandom) : opc;
      z   = (zMode == 2) ? coin() : 1'(zMode);
      runCycle(s, drv, z);
    end
  endtask

  task automatic runInstr(input int kind, input int fWait, input int mWait, input int zMode);
    trace.delete();
    pushInstr(kind, fWait, mWait);
    runTrace(opFor(kind), zMode);
  endtask

  task automatic doReset();
    applyStimulus(7'($urandom), 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    doReset();

    runInstr(KR, 0, 0, 2);
    runInstr(KLD, 0, 3, 2);
    runInstr(KBR, 0, 0, 1);
    runInstr(KBR, 0, 0, 0);
    runInstr(KI, 2, 0, 2);
    runInstr(KST, 1, 2, 2);

    // Illegal opcode: halt with sticky illegal until reset.
    trace.delete();
    push(ST_FETCH, 1'b1, 0, 0);
    push(ST_DECODE, coin(), 0, 0);
    repeat (10) push(ST_HALT, coin(), 1, 0);
    runTrace(7'b1111111, 2);
    doReset();
    runInstr(KR, 0, 0, 2);

    // Fetch timeout: count reaches the limit with mem_ready still low.
    doReset();
    trace.delete();
    repeat (TIMEOUT + 1) push(ST_FETCH, 1'b0, 0, 0);
    repeat (5) push(ST_HALT, coin(), 0, 1);
    runTrace(OPC_R, 2);

    // mem_ready arriving exactly at the limit is a normal fetch.
    doReset();
    runInstr(KI, TIMEOUT, 0, 2);

    // Timeout while waiting on a load.
    doReset();
    trace.delete();
    push(ST_FETCH, 1'b1, 0, 0);
    push(ST_DECODE, coin(), 0, 0);
    push(ST_MEM_ADDR, coin(), 0, 0);
    repeat (TIMEOUT + 1) push(ST_MEM_RD, 1'b0, 0, 0);
    repeat (3) push(ST_HALT, coin(), 0, 1);
    runTrace(OPC_LD, 2);

    // Reset in the middle of a stalled store.
    doReset();
    trace.delete();
    push(ST_FETCH, 1'b1, 0, 0);
    push(ST_DECODE, 1'b0, 0, 0);
    push(ST_MEM_ADDR, 1'b0, 0, 0);
    push(ST_MEM_WR, 1'b0, 0, 0);
    push(ST_MEM_WR, 1'b0, 0, 0);
    runTrace(OPC_ST, 2);
    applyStimulus(OPC_ST, 1'b0, 1'b0, 1'b1);
    checkOutput("memWriteInReset", {31'b0, mem_write}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    runInstr(KST, 0, 1, 2);

    repeat (40) runInstr(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                         int'($urandom_range(0, 4)), 2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
